// File: rtl/vending_machine.sv
// Two-product vending controller: Product 1 costs Rs.10 and Product 2 costs Rs.5.
// It accepts Rs.5/Rs.10, returns Rs.5 change on overpayment, and registers its outputs.
module vending_machine (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] choice,
  input  logic [3:0] money,
  output logic       delivery,
  output logic [3:0] change,
  output logic [2:0] states
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100,
    S5 = 3'b101
  } state_t;

  localparam logic [1:0] CHOICE_P1 = 2'b01;
  localparam logic [1:0] CHOICE_P2 = 2'b10;
  localparam logic [3:0] RS5       = 4'b0101;
  localparam logic [3:0] RS10      = 4'b1010;

  state_t     state_q, state_d;
  logic       delivery_q, delivery_d;
  logic [3:0] change_q, change_d;

  // Outputs are computed for the state being entered, so they appear together with s3/s5.
  always_comb begin
    state_d    = state_q;
    delivery_d = 1'b0;
    change_d   = '0;
    case (state_q)
      S0: begin
        if (choice == CHOICE_P1)      state_d = S1;
        else if (choice == CHOICE_P2) state_d = S4;
      end
      S1: begin
        if (money == RS10) begin
          state_d    = S3;
          delivery_d = 1'b1;
        end else if (money == RS5) begin
          state_d = S2;
        end
      end
      S2: begin
        if (money == RS5) begin
          state_d    = S3;
          delivery_d = 1'b1;
        end else if (money == RS10) begin
          state_d    = S3;
          delivery_d = 1'b1;
          change_d   = RS5;
        end
      end
      S4: begin
        if (money == RS5) begin
          state_d    = S5;
          delivery_d = 1'b1;
        end else if (money == RS10) begin
          state_d    = S5;
          delivery_d = 1'b1;
          change_d   = RS5;
        end
      end
      S3, S5:  state_d = S0;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S0;
      delivery_q <= 1'b0;
      change_q   <= '0;
    end else begin
      state_q    <= state_d;
      delivery_q <= delivery_d;
      change_q   <= change_d;
    end
  end

  assign delivery = delivery_q;
  assign change   = change_q;
  assign states   = state_q;

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: the driver queues the expected {states, delivery, change}
// for each edge, and a monitor pops and compares that value once per cycle.
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] choice;
  logic [3:0] money;
  logic       delivery;
  logic [3:0] change;
  logic [2:0] states;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q[$];

  vending_machine dut (
    .clk      (clk),
    .reset    (reset),
    .choice   (choice),
    .money    (money),
    .delivery (delivery),
    .change   (change),
    .states   (states)
  );

  always #5 clk = ~clk;

  // Drive one edge's inputs, then queue what the registers must hold after that edge.
  task automatic step(input logic r, input logic [1:0] c, input logic [3:0] m,
                      input logic [2:0] es, input logic ed, input logic [3:0] ec);
    @(negedge clk);
    reset  = r;
    choice = c;
    money  = m;
    @(posedge clk);
    #1;
    exp_q.push_back({es, ed, ec});
  endtask

  // Monitor: the outputs are registered, so sample on the negative edge.
  initial begin
    logic [7:0] e;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {states, delivery, change};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL check%0d: states/delivery/change got %b/%b/%b expected %b/%b/%b",
                   n_checks, a[7:5], a[4], a[3:0], e[7:5], e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; choice = 2'b00; money = 4'b0000;
    // Reset state
    step(1, 2'b00, 4'b0000, 3'b000, 0, 4'b0000);
    // Product 1 with Rs.10
    step(0, 2'b01, 4'b0000, 3'b001, 0, 4'b0000);
    step(0, 2'b00, 4'b1010, 3'b011, 1, 4'b0000);
    step(0, 2'b00, 4'b0000, 3'b000, 0, 4'b0000);
    // Product 1 with Rs.5 + Rs.5
    step(0, 2'b01, 4'b0000, 3'b001, 0, 4'b0000);
    step(0, 2'b00, 4'b0101, 3'b010, 0, 4'b0000);
    step(0, 2'b00, 4'b0101, 3'b011, 1, 4'b0000);
    step(0, 2'b00, 4'b0000, 3'b000, 0, 4'b0000);
    // Product 1 with Rs.5 + Rs.10 -> change
    step(0, 2'b01, 4'b0000, 3'b001, 0, 4'b0000);
    step(0, 2'b00, 4'b0101, 3'b010, 0, 4'b0000);
    step(0, 2'b00, 4'b1010, 3'b011, 1, 4'b0101);
    // choice=01 held during dispense must not start a new sale
    step(0, 2'b01, 4'b0000, 3'b000, 0, 4'b0000);
    // Product 2 with Rs.10 -> change
    step(0, 2'b10, 4'b0000, 3'b100, 0, 4'b0000);
    step(0, 2'b00, 4'b0011, 3'b100, 0, 4'b0000);
    step(0, 2'b00, 4'b1010, 3'b101, 1, 4'b0101);
    step(0, 2'b00, 4'b0000, 3'b000, 0, 4'b0000);
    // Product 2 with Rs.5
    step(0, 2'b10, 4'b0000, 3'b100, 0, 4'b0000);
    step(0, 2'b00, 4'b0101, 3'b101, 1, 4'b0000);
    step(0, 2'b00, 4'b0000, 3'b000, 0, 4'b0000);
    // Invalid choice; money ignored in idle
    step(0, 2'b11, 4'b0000, 3'b000, 0, 4'b0000);
    step(0, 2'b00, 4'b1010, 3'b000, 0, 4'b0000);
    // Invalid money held, idle money, choice change ignored in s1
    step(0, 2'b01, 4'b0000, 3'b001, 0, 4'b0000);
    step(0, 2'b00, 4'b0011, 3'b001, 0, 4'b0000);
    step(0, 2'b00, 4'b0011, 3'b001, 0, 4'b0000);
    step(0, 2'b00, 4'b0011, 3'b001, 0, 4'b0000);
    step(0, 2'b00, 4'b0000, 3'b001, 0, 4'b0000);
    step(0, 2'b10, 4'b0000, 3'b001, 0, 4'b0000);
    step(0, 2'b00, 4'b1111, 3'b001, 0, 4'b0000);
    step(0, 2'b00, 4'b1010, 3'b011, 1, 4'b0000);
    step(0, 2'b00, 4'b0000, 3'b000, 0, 4'b0000);
    // Invalid money in s2 stays put
    step(0, 2'b01, 4'b0000, 3'b001, 0, 4'b0000);
    step(0, 2'b00, 4'b0101, 3'b010, 0, 4'b0000);
    step(0, 2'b00, 4'b0110, 3'b010, 0, 4'b0000);
    // Mid-transaction reset beats a completing coin
    step(1, 2'b01, 4'b1010, 3'b000, 0, 4'b0000);
    step(0, 2'b10, 4'b0000, 3'b100, 0, 4'b0000);
    step(0, 2'b00, 4'b0101, 3'b101, 1, 4'b0000);
    step(0, 2'b00, 4'b0000, 3'b000, 0, 4'b0000);

    for (int unsigned i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
